// File: rtl/stoch_sub_sequencer.sv
// stoch_sub_sequencer
// Sequencer and stochastic number generator for a combinational stochastic
// subtractor. It takes an operand pair over a valid/ready handshake. It turns
// each operand into a BIT_LENGTH-bit stochastic stream by comparing it with an
// LFSR. It also builds a select stream, drives the subtractor one bit per
// clock, and counts the ones on y. The count is returned over an output
// handshake.
//
// Optional feature: define STOCH_SEQ_ABORT_EN to add the abort input and the
// aborted output. With it, a run can be cut short and the partial count returned.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a_val, b_val; p = val/256)
//   a, b, rand_bit       stochastic bits to the subtractor (0 outside RUN)
//   y                    subtractor output, combinational from a/b/rand_bit
//   out_valid/out_ready  result handshake carrying ones_count
//   busy                 high while a stream is being generated
//   abort, aborted       (STOCH_SEQ_ABORT_EN only) early stop / result tag
module stoch_sub_sequencer #(
    parameter int unsigned       WIDTH      = 8,
    parameter int unsigned       BIT_LENGTH = 128,
    parameter logic [WIDTH-1:0]  SEED_A     = 8'hA5,
    parameter logic [WIDTH-1:0]  SEED_B     = 8'h3C,
    parameter logic [WIDTH-1:0]  SEED_S     = 8'hE1,
    parameter int unsigned       CNT_W      = $clog2(BIT_LENGTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_val,
    input  logic [WIDTH-1:0] b_val,
    output logic             a,
    output logic             b,
    output logic             rand_bit,
    input  logic             y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] ones_count,
    output logic             busy
`ifdef STOCH_SEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam int unsigned      BIT_W    = $clog2(BIT_LENGTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BIT_LENGTH - 1);
    localparam logic [WIDTH-1:0] HALF     = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] lfsr_a;
    logic [WIDTH-1:0] lfsr_b;
    logic [WIDTH-1:0] lfsr_s;
    logic [BIT_W-1:0] bit_cnt;
    logic             run_end;
    logic             cut_short;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1: shift left, feedback into bit 0
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Stochastic streams, forced low outside RUN
    assign a        = (state == RUN) && (a_reg > lfsr_a);
    assign b        = (state == RUN) && (b_reg > lfsr_b);
    assign rand_bit = (state == RUN) && (lfsr_s < HALF);

    // Run termination: last bit, or an early abort when enabled
`ifdef STOCH_SEQ_ABORT_EN
    assign cut_short = abort && (bit_cnt != LAST_BIT);
`else
    assign cut_short = 1'b0;
`endif
    assign run_end = (bit_cnt == LAST_BIT) || cut_short;

    // Sequencer FSM with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            ones_count <= '0;
            bit_cnt    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            lfsr_a     <= SEED_A;
            lfsr_b     <= SEED_B;
            lfsr_s     <= SEED_S;
`ifdef STOCH_SEQ_ABORT_EN
            aborted    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Reseeding on every start makes identical operands repeatable
                    if (in_valid && in_ready) begin
                        a_reg      <= a_val;
                        b_reg      <= b_val;
                        lfsr_a     <= SEED_A;
                        lfsr_b     <= SEED_B;
                        lfsr_s     <= SEED_S;
                        ones_count <= '0;
                        bit_cnt    <= '0;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    ones_count <= ones_count + CNT_W'(y);
                    bit_cnt    <= bit_cnt + BIT_W'(1);
                    lfsr_a     <= lfsr_step(lfsr_a);
                    lfsr_b     <= lfsr_step(lfsr_b);
                    lfsr_s     <= lfsr_step(lfsr_s);
                    if (run_end) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
`ifdef STOCH_SEQ_ABORT_EN
                        aborted   <= cut_short;
`endif
                    end
                end
                HOLD: begin
                    // Return to IDLE only; the next start is taken a cycle later
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
`ifdef STOCH_SEQ_ABORT_EN
                        aborted   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stoch_sub_sequencer.sv
// Testbench for stoch_sub_sequencer. Stimulus pushes the expected result for
// each operation into a scoreboard queue. A negedge monitor pops that entry
// when out_valid rises and compares the count, latency, busy time and stream
// statistics against a golden LFSR/comparator model.
module tb_stoch_sub_sequencer;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned BIT_LENGTH = 128;
    localparam int unsigned CNT_W      = $clog2(BIT_LENGTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;
    logic             a;
    logic             b;
    logic             rand_bit;
    logic             y;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] ones_count;
    logic             busy;
`ifdef STOCH_SEQ_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    // 0: y tied 0, 1: y tied 1, 2: real MUX subtractor
    logic [1:0] y_mode;
    assign y = (y_mode == 2'd2) ? (rand_bit ? a : ~b) : y_mode[0];

    always #5 clk = ~clk;

    stoch_sub_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_val      (a_val),
        .b_val      (b_val),
        .a          (a),
        .b          (b),
        .rand_bit   (rand_bit),
        .y          (y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ones_count (ones_count),
        .busy       (busy)
`ifdef STOCH_SEQ_ABORT_EN
        ,
        .abort      (abort),
        .aborted    (aborted)
`endif
    );

    typedef struct {
        int cnt;
        int lat;
        int busy_n;
        int a_hi;
        int b_hi;
        int s_hi;
        int abrt;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    exp_t e_s;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   exp_acc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Golden model: seeded LFSRs, comparators and subtractor over nbits
    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                   input logic [1:0] mode, input int nbits);
        exp_t       e;
        logic [7:0] la = 8'hA5;
        logic [7:0] lb = 8'h3C;
        logic [7:0] ls = 8'hE1;
        logic       ab, bb, sel, yy;
        e.cnt = 0; e.a_hi = 0; e.b_hi = 0; e.s_hi = 0;
        e.lat = nbits + 1; e.busy_n = nbits; e.abrt = 0;
        for (int i = 0; i < nbits; i++) begin
            ab  = av > la;
            bb  = bv > lb;
            sel = ls < 8'h80;
            yy  = (mode == 2'd2) ? (sel ? ab : ~bb) : mode[0];
            e.cnt  += int'(yy);
            e.a_hi += int'(ab);
            e.b_hi += int'(bb);
            e.s_hi += int'(sel);
            la = {la[6:0], la[7] ^ la[5] ^ la[4] ^ la[3]};
            lb = {lb[6:0], lb[7] ^ lb[5] ^ lb[4] ^ lb[3]};
            ls = {ls[6:0], ls[7] ^ ls[5] ^ ls[4] ^ ls[3]};
        end
        return e;
    endfunction

    // Monitor: tracks each run from acceptance and scores it when out_valid rises
    int               acc_cyc = 0;
    int               busy_n  = 0;
    int               a_hi    = 0;
    int               b_hi    = 0;
    int               s_hi    = 0;
    logic             prev_ov = 1'b0;
    logic             unstable = 1'b0;
    logic [CNT_W-1:0] held = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                n_acc++;
                acc_cyc = cyc;
                busy_n = 0; a_hi = 0; b_hi = 0; s_hi = 0;
            end
            if (busy)     busy_n++;
            if (a)        a_hi++;
            if (b)        b_hi++;
            if (rand_bit) s_hi++;
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e_m = sb.pop_front();
                    chk("ones_count", int'(ones_count), e_m.cnt);
                    chk("latency", cyc - acc_cyc, e_m.lat);
                    chk("busy_cycles", busy_n, e_m.busy_n);
                    chk("a_ones", a_hi, e_m.a_hi);
                    chk("b_ones", b_hi, e_m.b_hi);
                    chk("sel_ones", s_hi, e_m.s_hi);
`ifdef STOCH_SEQ_ABORT_EN
                    chk("aborted", int'(aborted), e_m.abrt);
`endif
                end
                held = ones_count;
                unstable = 1'b0;
            end else if (out_valid && ones_count != held) begin
                unstable = 1'b1;
            end
            if (out_valid && out_ready) chk("hold_stable", int'(unstable), 0);
            prev_ov = out_valid;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [7:0] av, input logic [7:0] bv,
                         input logic [1:0] mode, input bit push);
        wait_idle();
        y_mode   = mode;
        a_val    = av;
        b_val    = bv;
        in_valid = 1'b1;
        if (push) sb.push_back(model(av, bv, mode, BIT_LENGTH));
        exp_acc++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic consume(input int hold, input bit poke);
        int n = 0;
        while (!out_valid && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        repeat (hold) begin
            if (poke) begin
                in_valid = 1'b1;
                a_val    = 8'hFF;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"},   int'(in_ready),   1);
        chk({tag, "_out_valid"},  int'(out_valid),  0);
        chk({tag, "_busy"},       int'(busy),       0);
        chk({tag, "_ones_count"}, int'(ones_count), 0);
        chk({tag, "_a"},          int'(a),          0);
        chk({tag, "_b"},          int'(b),          0);
        chk({tag, "_rand_bit"},   int'(rand_bit),   0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_val     = '0;
        b_val     = '0;
        y_mode    = 2'd0;
`ifdef STOCH_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // y tied 1: every bit counts
        issue(8'h40, 8'h40, 2'd1, 1'b1);
        consume(0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("idle_keeps_count", int'(ones_count), 128);

        // y tied 0: nothing counts
        issue(8'h40, 8'h40, 2'd0, 1'b1);
        consume(0, 1'b0);

        // a_val = 0 against the real subtractor: a never rises
        issue(8'h00, 8'h55, 2'd2, 1'b1);
        consume(0, 1'b0);

        // Back-to-back identical operands give identical, model-exact counts
        issue(8'h90, 8'h30, 2'd2, 1'b1);
        consume(0, 1'b0);
        issue(8'h90, 8'h30, 2'd2, 1'b1);
        consume(0, 1'b0);

        // in_valid pulses during RUN and a 20-cycle HOLD are ignored
        issue(8'h90, 8'h30, 2'd2, 1'b1);
        repeat (30) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        a_val    = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        consume(20, 1'b1);

        // Reset at bit 50 discards the run; the next run restarts from the seeds
        issue(8'h40, 8'h40, 2'd1, 1'b0);
        repeat (50) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("midrun_reset");
        @(posedge clk); #1;
        issue(8'h90, 8'h30, 2'd2, 1'b1);
        consume(0, 1'b0);

`ifdef STOCH_SEQ_ABORT_EN
        // Abort at bit index 9 with y tied 1: ten bits counted
        issue(8'h40, 8'h40, 2'd1, 1'b0);
        e_s = model(8'h40, 8'h40, 2'd1, 10);
        e_s.abrt = 1;
        sb.push_back(e_s);
        repeat (9) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        consume(0, 1'b0);
`endif

        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_empty", sb.size(), 0);
        chk("accept_count", n_acc, exp_acc);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stoch_sub_sequencer.md
Name: stoch_sub_sequencer

Overview:
- Sequencer and stochastic number generator (SNG) for the combinational stochastic subtractor (ports a, b, rand_bit, y).
- Accepts two binary operands over a valid/ready handshake and converts each into a BIT_LENGTH-bit stochastic stream using LFSR comparators.
- Generates the select stream, drives the subtractor one bit per clock, and counts the ones on y.
- Returns the ones count over an output handshake; replaces file-driven stimulus in system-level use.

Parameters:
- WIDTH, 8: operand resolution; LFSR width. Only 8 supported; taps fixed (x^8+x^6+x^5+x^4+1).
- BIT_LENGTH, 128: stream length in bits per operation; must be at least 2.
- SEED_A, 8'hA5: reset/reload seed of operand-A LFSR; must be nonzero.
- SEED_B, 8'h3C: seed of operand-B LFSR; must be nonzero.
- SEED_S, 8'hE1: seed of select LFSR; must be nonzero.
- CNT_W, $clog2(BIT_LENGTH+1): ones-counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept operands
- a_val  in  WIDTH  operand A probability numerator (p = a_val/256)
- b_val  in  WIDTH  operand B probability numerator
- a  out  1  stochastic bit of A to subtractor
- b  out  1  stochastic bit of B to subtractor
- rand_bit  out  1  select bit to subtractor
- y  in  1  subtractor output, combinational from a/b/rand_bit
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- ones_count  out  CNT_W  number of y==1 bits over the run
- busy  out  1  high in RUN

Behaviour:
- FSM states IDLE, RUN, HOLD. Reset → IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, ones_count=0, a=b=rand_bit=0, bit counter=0, LFSRs=seeds.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register a_val/b_val, reload all three LFSRs with seeds, clear counters, go to RUN.
  - Reloading on every start makes identical operands give identical counts.
- RUN: lasts exactly BIT_LENGTH cycles; in_ready=0, busy=1.
  - Each cycle, combinationally: a=(a_reg > lfsr_a), b=(b_reg > lfsr_b), rand_bit=(lfsr_s < 8'h80).
  - y is sampled the same cycle. At the clock edge: ones_cnt += y, bit_cnt += 1, and all LFSRs step (shift left, feedback into bit 0).
  - After the edge where bit_cnt==BIT_LENGTH-1: go to HOLD.
- Outputs outside RUN: a, b and rand_bit are forced to 0.
- HOLD:
  - out_valid=1; ones_count holds its final value and is stable until the handshake completes.
  - On out_ready: out_valid=0, go to IDLE. The next operand is accepted no earlier than the following cycle (no same-cycle restart).
- Latency: operand acceptance to out_valid = BIT_LENGTH+1 cycles. Throughput is one operation per BIT_LENGTH+2 cycles minimum.
- ones_count in IDLE keeps the last result. It clears only when a new operand is accepted.
- Counter saturation: cannot occur; CNT_W covers BIT_LENGTH.
- in_valid during RUN or HOLD: ignored, not queued.
- out_ready outside HOLD: ignored.
- rst asserted mid-RUN or in HOLD: full return to reset values next edge; partial result discarded, no out_valid.
- Operand boundaries:
  - a_val=0 → a constantly 0.
  - a_val=255 → a=1 except when lfsr_a=255 (once per 255-cycle period).
- LFSR lock-up: never reaches 0, since seeds are nonzero and taps are maximal.

Optional Feature:
- Macro STOCH_SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort high in RUN: the next edge goes to HOLD with ones_count equal to the bits counted so far, including the current cycle's y.
  - Adds output aborted (1 bit), high with out_valid when the run was cut short, cleared on the output handshake.
  - abort is ignored in IDLE and HOLD.
- Undefined: neither port exists; RUN always completes BIT_LENGTH bits.

Test Plan:
- y tied 1, a_val=b_val=8'h40, one start → out_valid exactly 129 cycles after acceptance, ones_count=128, busy high for 128 cycles.
- y tied 0 → ones_count=0. Then a_val=0 run with the real MUX subtractor (y = rand_bit ? a : ~b) → a never 1 across all 128 cycles.
- Two back-to-back runs with a_val=8'h90, b_val=8'h30 against the real subtractor → both ones_count values equal and match a golden LFSR/comparator model bit-for-bit.
- Hold out_ready=0 for 20 cycles in HOLD → out_valid and ones_count stable; in_valid pulses during RUN/HOLD are not accepted (in_ready=0).
- Assert rst at bit 50 of a run → next cycle in_ready=1, out_valid=0, ones_count=0, a=b=rand_bit=0; following run matches the golden model from seed.
- STOCH_SEQ_ABORT_EN, y tied 1, abort at bit index 9 → HOLD with ones_count=10 and aborted=1; without the macro the abort port is absent and compilation still succeeds.
